// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: types and constants shared by the byte-serial RAM controller.
//   - mem_state_e : controller FSM encoding (MemCtrlIdle..MemCtrlDone)
//   - MemAddrBus / ByteBus / MemDataBus : bus typedefs
//   - IoRegionTag : addr[17:16] value that marks the UART/IO region
//   - norm_len()  : maps a request byte count onto 1, 2 or 4
package mem_ctrl_pkg;

    localparam int MEM_ADDR_W = 32;

    typedef logic [MEM_ADDR_W-1:0] MemAddrBus;
    typedef logic [7:0]            ByteBus;
    typedef logic [31:0]           MemDataBus;

    typedef enum logic [2:0] {
        MemCtrlIdle  = 3'd0,
        MemCtrlFetch = 3'd1,
        MemCtrlLoad  = 3'd2,
        MemCtrlStore = 3'd3,
        MemCtrlDone  = 3'd4
    } mem_state_e;

    localparam logic [1:0] IoRegionTag = 2'b11;

    // Anything other than 1 or 2 is a full word access.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        case (len)
            3'd1:    norm_len = 3'd1;
            3'd2:    norm_len = 3'd2;
            default: norm_len = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_byte_assembler.sv
// mem_ctrl_byte_assembler: 4-byte little-endian assembly register for reads.
//   clock, reset : clock, asynchronous active-low reset
//   start        : clear the word (new read transaction)
//   cap_en       : write cap_byte into byte lane cap_idx
//   cap_idx      : destination byte lane (0 = bits 7:0)
//   cap_byte     : byte returned by the RAM
//   word_next    : value the register takes at the next edge, so the
//                  controller can publish a complete word in the same cycle
//                  the last byte arrives
module mem_ctrl_byte_assembler
    import mem_ctrl_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      start,
    input  logic      cap_en,
    input  logic [1:0] cap_idx,
    input  ByteBus    cap_byte,
    output MemDataBus word_next
);

    MemDataBus word_q;
    MemDataBus word_d;

    always_comb begin
        word_d = word_q;
        if (start) begin
            word_d = '0;
        end else if (cap_en) begin
            word_d[{cap_idx, 3'b000} +: 8] = cap_byte;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_next = word_d;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: single owner of the byte-wide RAM port. Arbitrates instruction
// fetch (4 bytes), data load (1/2/4 bytes) and data store (1/2/4 bytes) and
// serialises each access into one-byte RAM cycles.
//
// Ports:
//   clock, reset         : clock, asynchronous active-low reset
//   clear                : pipeline flush, aborts a fetch only
//   if_req/if_addr       : fetch request / base address
//   if_done/if_data      : fetch completion pulse / fetched word
//   ls_req/ls_write/ls_length/ls_addr/ls_wdata : load/store request
//   ls_done/ls_rdata     : load/store completion pulse / zero-extended load data
//   io_full              : UART output buffer full
//   ram_write/ram_addr/ram_wdata/ram_rdata : byte RAM port (read data one cycle
//                          after the address)
//   dbg_state            : current FSM state (mem_state_e encoding)
//
// Handshake: *_req is a level that the requester holds, with stable fields,
// until the matching *_done pulse; the controller latches the fields when it
// accepts the request in IDLE and the requester drops req the cycle after
// done, so a finished request is never accepted twice. ls_req wins over if_req.
//
// Build option: MEM_CTRL_IO_STALL_EN -- when defined, store bytes addressed to
// the IO region (addr[17:16] == IoRegionTag) wait while io_full is high.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_write,
    input  logic [2:0]        ls_length,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic              io_full,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [2:0]        dbg_state
);

    mem_state_e        state_q, state_d;
    mem_state_e        kind_q, kind_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic [ADDR_W-1:0] base_q, base_d;
    MemDataBus         wdata_q, wdata_d;
    MemDataBus         if_data_q, if_data_d;
    MemDataBus         ls_rdata_q, ls_rdata_d;
    logic              if_done_q, if_done_d;
    logic              ls_done_q, ls_done_d;
    logic              ram_write_q, ram_write_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    ByteBus            ram_wdata_q, ram_wdata_d;

    logic [ADDR_W-1:0] addr_d;
    logic              stall_d;
    logic              asm_start;
    logic              cap_en;
    logic [1:0]        cap_idx;
    MemDataBus         asm_word;

    mem_ctrl_byte_assembler u_asm (
        .clock     (clock),
        .reset     (reset),
        .start     (asm_start),
        .cap_en    (cap_en),
        .cap_idx   (cap_idx),
        .cap_byte  (ram_rdata),
        .word_next (asm_word)
    );

    // Byte address of the cycle being set up for the next clock.
    assign addr_d = base_d + ADDR_W'(cnt_d);

`ifdef MEM_CTRL_IO_STALL_EN
    assign stall_d = (addr_d[17:16] == IoRegionTag) && io_full;
`else
    logic io_full_unused;
    assign io_full_unused = io_full;
    assign stall_d        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        asm_start  = 1'b0;
        cap_en     = 1'b0;
        cap_idx    = 2'(cnt_q - 3'd1);

        unique case (state_q)
            MemCtrlIdle: begin
                if (ls_req) begin
                    asm_start = 1'b1;
                    base_d    = ls_addr;
                    len_d     = norm_len(ls_length);
                    wdata_d   = ls_wdata;
                    cnt_d     = 3'd0;
                    state_d   = ls_write ? MemCtrlStore : MemCtrlLoad;
                    kind_d    = ls_write ? MemCtrlStore : MemCtrlLoad;
                end else if (if_req && !clear) begin
                    asm_start = 1'b1;
                    base_d    = if_addr;
                    len_d     = 3'd4;
                    cnt_d     = 3'd0;
                    state_d   = MemCtrlFetch;
                    kind_d    = MemCtrlFetch;
                end
            end

            MemCtrlFetch, MemCtrlLoad: begin
                // Byte cnt-1 arrives this cycle (address was driven last cycle).
                cap_en = (cnt_q != 3'd0);
                if (state_q == MemCtrlFetch && clear) begin
                    state_d = MemCtrlIdle;
                    cnt_d   = 3'd0;
                end else if (cnt_q == len_q) begin
                    state_d = MemCtrlDone;
                    cnt_d   = 3'd0;
                    if (state_q == MemCtrlFetch) begin
                        if_data_d = asm_word;
                        if_done_d = 1'b1;
                    end else begin
                        ls_rdata_d = asm_word;
                        ls_done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            MemCtrlStore: begin
                // A byte only advances when its write strobe actually issued.
                if (ram_write_q) begin
                    if (cnt_q == len_q - 3'd1) begin
                        state_d   = MemCtrlDone;
                        cnt_d     = 3'd0;
                        ls_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            MemCtrlDone: begin
                state_d = MemCtrlIdle;
                cnt_d   = 3'd0;
            end

            default: begin
                state_d = MemCtrlIdle;
                cnt_d   = 3'd0;
            end
        endcase

        // RAM port outputs for the next cycle, derived from the next state.
        ram_write_d = 1'b0;
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        case (state_d)
            MemCtrlStore: begin
                ram_addr_d  = addr_d;
                ram_wdata_d = wdata_d[{cnt_d[1:0], 3'b000} +: 8];
                ram_write_d = !stall_d;
            end
            MemCtrlFetch, MemCtrlLoad: begin
                if (cnt_d < len_d) begin
                    ram_addr_d = addr_d;
                end
            end
            default: begin
                ram_addr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= MemCtrlIdle;
            kind_q      <= MemCtrlIdle;
            cnt_q       <= '0;
            len_q       <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            if_data_q   <= '0;
            ls_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            ram_write_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            if_data_q   <= if_data_d;
            ls_rdata_q  <= ls_rdata_d;
            if_done_q   <= if_done_d;
            ls_done_q   <= ls_done_d;
            ram_write_q <= ram_write_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // A flush arriving in the fetch's done cycle cancels the pulse.
    assign if_done   = if_done_q && !clear;
    assign ls_done   = ls_done_q;
    assign if_data   = if_data_q;
    assign ls_rdata  = ls_rdata_q;
    assign ram_write = ram_write_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl. A small ROM function stands in for
// the RAM (read data one cycle after the address); stores are checked on the
// RAM port byte by byte.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clock;
    logic        reset;
    logic        clear;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_write;
    logic [2:0]  ls_length;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        io_full;
    logic        ram_write;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_data   (if_data),
        .ls_req    (ls_req),
        .ls_write  (ls_write),
        .ls_length (ls_length),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_done   (ls_done),
        .ls_rdata  (ls_rdata),
        .io_full   (io_full),
        .ram_write (ram_write),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- RAM model ----------------
    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        case (a)
            32'h0000_0100: rom_byte = 8'h13;
            32'h0000_0101: rom_byte = 8'h05;
            32'h0000_0102: rom_byte = 8'h00;
            32'h0000_0103: rom_byte = 8'h00;
            32'h0000_0104: rom_byte = 8'h67;
            32'h0000_0105: rom_byte = 8'h45;
            32'h0000_0106: rom_byte = 8'h23;
            32'h0000_0107: rom_byte = 8'h01;
            32'h0000_0020: rom_byte = 8'hAA;
            32'h0000_0021: rom_byte = 8'hBB;
            32'h0000_0040: rom_byte = 8'hEF;
            32'h0000_0041: rom_byte = 8'hBE;
            32'h0000_0042: rom_byte = 8'hAD;
            32'h0000_0043: rom_byte = 8'hDE;
            32'hFFFF_FFFF: rom_byte = 8'h11;
            32'h0000_0000: rom_byte = 8'h22;
            default:       rom_byte = 8'h5C;
        endcase
    endfunction

    always @(posedge clock) ram_rdata <= rom_byte(ram_addr);

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_if_done(input string tag);
        int n;
        n = 0;
        while (!if_done && n < 20) begin
            tick();
            n++;
        end
        check(tag, {31'd0, if_done}, 32'd1);
    endtask

    task automatic drive_ls(input logic wr, input logic [2:0] len,
                            input logic [31:0] addr, input logic [31:0] wd);
        ls_req    = 1'b1;
        ls_write  = wr;
        ls_length = len;
        ls_addr   = addr;
        ls_wdata  = wd;
    endtask

    task automatic drive_fetch(input logic [31:0] addr);
        if_req  = 1'b1;
        if_addr = addr;
    endtask

    task automatic check_state(input string tag, input mem_state_e s);
        check(tag, {29'd0, dbg_state}, {29'd0, s});
    endtask

    logic [31:0] wd;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b0; clear = 1'b0; if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_write = 1'b0; ls_length = '0; ls_addr = '0; ls_wdata = '0;
        io_full = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        // reset state
        check("rst_ram_write", {31'd0, ram_write}, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
        check("rst_if_done", {31'd0, if_done}, 32'd0);
        check("rst_ls_done", {31'd0, ls_done}, 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_ls_rdata", ls_rdata, 32'd0);
        check_state("rst_state", MemCtrlIdle);
        reset = 1'b1;
        tick();

        // fetch at 0x100
        drive_fetch(32'h100);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fetch_addr", ram_addr, 32'h100 + 32'(i));
            check("fetch_no_write", {31'd0, ram_write}, 32'd0);
            check("fetch_early_done", {31'd0, if_done}, 32'd0);
        end
        tick();
        check("fetch_tail_addr", ram_addr, 32'd0);
        check("fetch_tail_done", {31'd0, if_done}, 32'd0);
        tick();
        check("fetch_done", {31'd0, if_done}, 32'd1);
        check("fetch_data", if_data, 32'h0000_0513);
        check_state("fetch_done_state", MemCtrlDone);
        tick();
        if_req = 1'b0;
        check("fetch_done_pulse", {31'd0, if_done}, 32'd0);
        check_state("fetch_back_idle", MemCtrlIdle);
        tick();
        check_state("fetch_no_reaccept", MemCtrlIdle);

        // simultaneous fetch and load: load wins
        drive_fetch(32'h100);
        drive_ls(1'b0, 3'd2, 32'h20, 32'h0);
        tick();
        check_state("arb_load_first", MemCtrlLoad);
        check("arb_load_addr0", ram_addr, 32'h20);
        tick();
        check("arb_load_addr1", ram_addr, 32'h21);
        tick();
        check("arb_load_tail", ram_addr, 32'd0);
        check("arb_load_early", {31'd0, ls_done}, 32'd0);
        tick();
        check("arb_load_done", {31'd0, ls_done}, 32'd1);
        check("arb_load_data", ls_rdata, 32'h0000_BBAA);
        check("arb_no_if_done", {31'd0, if_done}, 32'd0);
        tick();
        ls_req = 1'b0;
        check_state("arb_idle", MemCtrlIdle);
        check("arb_ls_pulse", {31'd0, ls_done}, 32'd0);
        tick();
        check_state("arb_fetch_next", MemCtrlFetch);
        check("arb_fetch_addr", ram_addr, 32'h100);
        wait_if_done("arb_fetch_done");
        check("arb_fetch_data", if_data, 32'h0000_0513);
        check("arb_ls_rdata_held", ls_rdata, 32'h0000_BBAA);
        tick();
        if_req = 1'b0;
        tick();

        // store 4 bytes at 0x40
        wd = 32'hDEAD_BEEF;
        drive_ls(1'b1, 3'd4, 32'h40, wd);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("store_write", {31'd0, ram_write}, 32'd1);
            check("store_addr", ram_addr, 32'h40 + 32'(i));
            check("store_wdata", {24'd0, ram_wdata}, {24'd0, wd[8*i +: 8]});
            check("store_early_done", {31'd0, ls_done}, 32'd0);
        end
        tick();
        check("store_done", {31'd0, ls_done}, 32'd1);
        check("store_done_nowrite", {31'd0, ram_write}, 32'd0);
        check("store_done_wdata", {24'd0, ram_wdata}, 32'd0);
        tick();
        ls_req = 1'b0;
        check_state("store_idle", MemCtrlIdle);
        tick();

        // load wrapping past 0xFFFFFFFF
        drive_ls(1'b0, 3'd2, 32'hFFFF_FFFF, 32'h0);
        tick();
        check("wrap_addr0", ram_addr, 32'hFFFF_FFFF);
        tick();
        check("wrap_addr1", ram_addr, 32'h0000_0000);
        tick();
        tick();
        check("wrap_done", {31'd0, ls_done}, 32'd1);
        check("wrap_data", ls_rdata, 32'h0000_2211);
        tick();
        ls_req = 1'b0;
        tick();

        // illegal length 3 behaves as a word load
        drive_ls(1'b0, 3'd3, 32'h40, 32'h0);
        tick();
        check("len3_addr0", ram_addr, 32'h40);
        tick(); tick(); tick();
        check("len3_addr3", ram_addr, 32'h43);
        tick();
        check("len3_not_early", {31'd0, ls_done}, 32'd0);
        tick();
        check("len3_done", {31'd0, ls_done}, 32'd1);
        check("len3_data", ls_rdata, 32'hDEAD_BEEF);
        tick();
        ls_req = 1'b0;
        tick();

        // byte load zero-extends over previous word
        drive_ls(1'b0, 3'd1, 32'h43, 32'h0);
        tick();
        check("len1_addr", ram_addr, 32'h43);
        tick();
        check("len1_tail", ram_addr, 32'd0);
        tick();
        check("len1_done", {31'd0, ls_done}, 32'd1);
        check("len1_data", ls_rdata, 32'h0000_00DE);
        tick();
        ls_req = 1'b0;
        tick();

        // clear at cnt=2 of a fetch aborts it
        drive_fetch(32'h104);
        tick(); tick(); tick();
        check_state("clr_in_fetch", MemCtrlFetch);
        check("clr_addr_cnt2", ram_addr, 32'h106);
        clear = 1'b1;
        tick();
        check_state("clr_idle", MemCtrlIdle);
        check("clr_no_done", {31'd0, if_done}, 32'd0);
        check("clr_addr_zero", ram_addr, 32'd0);
        clear = 1'b0;
        if_addr = 32'h100;
        tick();
        check_state("clr_refetch", MemCtrlFetch);
        check("clr_refetch_addr", ram_addr, 32'h100);
        wait_if_done("clr_refetch_done");
        check("clr_refetch_data", if_data, 32'h0000_0513);
        tick();
        if_req = 1'b0;
        tick();

        // clear during the fetch's done cycle suppresses if_done
        drive_fetch(32'h104);
        repeat (6) tick();
        check_state("clr_done_state", MemCtrlDone);
        clear = 1'b1;
        #1;
        check("clr_done_suppressed", {31'd0, if_done}, 32'd0);
        clear = 1'b0;
        tick();
        if_req = 1'b0;
        check_state("clr_done_idle", MemCtrlIdle);
        check("clr_done_after", {31'd0, if_done}, 32'd0);
        tick();

        // reset during third byte of a store
        drive_ls(1'b1, 3'd4, 32'h80, 32'h1122_3344);
        tick(); tick(); tick();
        check("rst_mid_write_before", {31'd0, ram_write}, 32'd1);
        check("rst_mid_addr_before", ram_addr, 32'h82);
        check("rst_mid_wdata_before", {24'd0, ram_wdata}, 32'h22);
        reset = 1'b0;
        #1;
        check("rst_mid_write", {31'd0, ram_write}, 32'd0);
        check("rst_mid_addr", ram_addr, 32'd0);
        check("rst_mid_wdata", {24'd0, ram_wdata}, 32'd0);
        check_state("rst_mid_state", MemCtrlIdle);
        ls_req = 1'b0;
        #3;
        reset = 1'b1;
        tick();
        check_state("rst_mid_after", MemCtrlIdle);
        check("rst_mid_after_write", {31'd0, ram_write}, 32'd0);
        check("rst_mid_after_done", {31'd0, ls_done}, 32'd0);
        tick();

        // store to the IO region with the UART buffer full
        io_full = 1'b1;
        drive_ls(1'b1, 3'd1, 32'h0003_0000, 32'h0000_005A);
`ifdef MEM_CTRL_IO_STALL_EN
        tick();
        check("io_stall_1", {31'd0, ram_write}, 32'd0);
        tick();
        check("io_stall_2", {31'd0, ram_write}, 32'd0);
        tick();
        check("io_stall_3", {31'd0, ram_write}, 32'd0);
        io_full = 1'b0;
        tick();
        check("io_write", {31'd0, ram_write}, 32'd1);
        check("io_addr", ram_addr, 32'h0003_0000);
        check("io_wdata", {24'd0, ram_wdata}, 32'h5A);
        check("io_not_early", {31'd0, ls_done}, 32'd0);
        tick();
        check("io_done", {31'd0, ls_done}, 32'd1);
`else
        tick();
        check("io_write", {31'd0, ram_write}, 32'd1);
        check("io_addr", ram_addr, 32'h0003_0000);
        check("io_wdata", {24'd0, ram_wdata}, 32'h5A);
        tick();
        check("io_done", {31'd0, ls_done}, 32'd1);
`endif
        tick();
        ls_req  = 1'b0;
        io_full = 1'b0;
        check_state("io_idle", MemCtrlIdle);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
